// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract with ARM-style NZCV flags and a sideband tag.
// One carry-chained segment per stage; a single global stall freezes every stage.
module pipe_adder #(
    parameter int WIDTH    = 64,
    parameter int SEGMENTS = 4,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] add_out,
    output logic [3:0]       flags_out,
    output logic [TAG_W-1:0] tag_out
);
    localparam int SW = (SEGMENTS > 0) ? WIDTH / SEGMENTS : WIDTH;

    if (SEGMENTS < 1) begin : g_bad_segments
        $error("pipe_adder: SEGMENTS must be at least 1");
    end else if ((WIDTH % SEGMENTS) != 0) begin : g_bad_split
        $error("pipe_adder: SEGMENTS must divide WIDTH exactly");
    end

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage
        // Operand bits not yet consumed: this stage's slice sits in the low SW bits.
        localparam int OW = WIDTH - k * SW;

        logic [OW-1:0]         a_src;
        logic [OW-1:0]         b_src;
        logic                  c_src;
        logic                  z_src;
        logic                  v_src;
        logic [TAG_W-1:0]      t_src;
        logic [SW:0]           seg;
        logic                  v_q;
        logic [TAG_W-1:0]      t_q;
        logic [(k+1)*SW-1:0]   s_q;

        assign seg = {1'b0, a_src[SW-1:0]} + {1'b0, b_src[SW-1:0]} + {{SW{1'b0}}, c_src};

        if (k == 0) begin : g_src
            assign a_src = a_in;
            assign b_src = sub_in ? ~b_in : b_in;
            assign c_src = sub_in;
            assign z_src = 1'b1;
            assign v_src = in_valid;
            assign t_src = tag_in;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    s_q <= '0;
                else if (advance)
                    s_q <= seg[SW-1:0];
            end
        end else begin : g_src
            assign a_src = g_stage[k-1].g_mid.a_q;
            assign b_src = g_stage[k-1].g_mid.b_q;
            assign c_src = g_stage[k-1].g_mid.c_q;
            assign z_src = g_stage[k-1].g_mid.z_q;
            assign v_src = g_stage[k-1].v_q;
            assign t_src = g_stage[k-1].t_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    s_q <= '0;
                else if (advance)
                    s_q <= {seg[SW-1:0], g_stage[k-1].s_q};
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v_q <= 1'b0;
                t_q <= '0;
            end else if (advance) begin
                v_q <= v_src;
                t_q <= t_src;
            end
        end

        if (k < SEGMENTS - 1) begin : g_mid
            logic [OW-SW-1:0] a_q;
            logic [OW-SW-1:0] b_q;
            logic             c_q;
            logic             z_q;

            // Zero is accumulated slice by slice to avoid a full-width reduction.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                    z_q <= 1'b0;
                end else if (advance) begin
                    a_q <= a_src[OW-1:SW];
                    b_q <= b_src[OW-1:SW];
                    c_q <= seg[SW];
                    z_q <= z_src && (seg[SW-1:0] == '0);
                end
            end
        end else begin : g_last
            logic [3:0] f_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    f_q <= 4'b0000;
                else if (advance)
                    f_q <= {seg[SW-1],
                            z_src && (seg[SW-1:0] == '0),
                            seg[SW],
                            (a_src[OW-1] == b_src[OW-1]) && (seg[SW-1] != a_src[OW-1])};
            end
        end
    end

    assign out_valid = g_stage[SEGMENTS-1].v_q;
    assign add_out   = g_stage[SEGMENTS-1].s_q;
    assign flags_out = g_stage[SEGMENTS-1].g_last.f_q;
    assign tag_out   = g_stage[SEGMENTS-1].t_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: flag vectors across four geometries, streaming with
// backpressure, and reset while results are in flight.
module tb_pipe_adder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        sw_valid = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic [4:0]  tag = '0;

    logic        rdy4, ov4, rdy1, ov1, rdy8, ov8, rdy2, ov2;
    logic [63:0] sum4, sum1, sum8;
    logic [31:0] sum2;
    logic [3:0]  fl4, fl1, fl8, fl2;
    logic [4:0]  tg4, tg1, tg8, tg2;

    pipe_adder #(.WIDTH(64), .SEGMENTS(4), .TAG_W(5)) u4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy4),
        .a_in(a), .b_in(b), .sub_in(sub), .tag_in(tag), .out_valid(ov4),
        .out_ready(out_ready), .add_out(sum4), .flags_out(fl4), .tag_out(tg4));
    pipe_adder #(.WIDTH(64), .SEGMENTS(1), .TAG_W(5)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(sw_valid), .in_ready(rdy1),
        .a_in(a), .b_in(b), .sub_in(sub), .tag_in(tag), .out_valid(ov1),
        .out_ready(out_ready), .add_out(sum1), .flags_out(fl1), .tag_out(tg1));
    pipe_adder #(.WIDTH(64), .SEGMENTS(8), .TAG_W(5)) u8 (
        .clk(clk), .reset_n(reset_n), .in_valid(sw_valid), .in_ready(rdy8),
        .a_in(a), .b_in(b), .sub_in(sub), .tag_in(tag), .out_valid(ov8),
        .out_ready(out_ready), .add_out(sum8), .flags_out(fl8), .tag_out(tg8));
    pipe_adder #(.WIDTH(32), .SEGMENTS(2), .TAG_W(5)) u2 (
        .clk(clk), .reset_n(reset_n), .in_valid(sw_valid), .in_ready(rdy2),
        .a_in(a32), .b_in(b32), .sub_in(sub), .tag_in(tag), .out_valid(ov2),
        .out_ready(out_ready), .add_out(sum2), .flags_out(fl2), .tag_out(tg2));

    int total = 0;
    int bad = 0;

    task automatic chk(input string what, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", what, obs, exp);
        end
    endtask

    logic [63:0] va [6];
    logic [63:0] vb [6];
    logic [31:0] va32 [6];
    logic [31:0] vb32 [6];
    logic        vs [6];
    logic [63:0] ve [6];
    logic [3:0]  vf [6];
    logic [31:0] ve32 [6];
    logic [3:0]  vf32 [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcv;
        logic acc;
        logic ret;

        va[0] = 64'd5;                 vb[0] = 64'd7; vs[0] = 1'b0;
        ve[0] = 64'd12;                vf[0] = 4'b0000;
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'd1; vs[1] = 1'b0;
        ve[1] = 64'd0;                 vf[1] = 4'b0110;
        va[2] = 64'd3;                 vb[2] = 64'd5; vs[2] = 1'b1;
        ve[2] = 64'hFFFF_FFFF_FFFF_FFFE; vf[2] = 4'b1000;
        va[3] = 64'd5;                 vb[3] = 64'd5; vs[3] = 1'b1;
        ve[3] = 64'd0;                 vf[3] = 4'b0110;
        va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'd1; vs[4] = 1'b1;
        ve[4] = 64'h7FFF_FFFF_FFFF_FFFF; vf[4] = 4'b0011;
        va[5] = 64'h7FFF_FFFF_FFFF_FFFF; vb[5] = 64'd1; vs[5] = 1'b0;
        ve[5] = 64'h8000_0000_0000_0000; vf[5] = 4'b1001;

        va32[0] = 32'd5;          vb32[0] = 32'd7; ve32[0] = 32'd12;          vf32[0] = 4'b0000;
        va32[1] = 32'hFFFF_FFFF;  vb32[1] = 32'd1; ve32[1] = 32'd0;           vf32[1] = 4'b0110;
        va32[2] = 32'd3;          vb32[2] = 32'd5; ve32[2] = 32'hFFFF_FFFE;   vf32[2] = 4'b1000;
        va32[3] = 32'd5;          vb32[3] = 32'd5; ve32[3] = 32'd0;           vf32[3] = 4'b0110;
        va32[4] = 32'h8000_0000;  vb32[4] = 32'd1; ve32[4] = 32'h7FFF_FFFF;   vf32[4] = 4'b0011;
        va32[5] = 32'h7FFF_FFFF;  vb32[5] = 32'd1; ve32[5] = 32'h8000_0000;   vf32[5] = 4'b1001;

        // Reset state while reset_n is held low.
        #12;
        chk("reset_valid", {63'd0, ov4}, 64'd0);
        chk("reset_sum", sum4, 64'd0);
        chk("reset_flags", {60'd0, fl4}, 64'd0);
        chk("reset_tag", {59'd0, tg4}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", {63'd0, rdy4}, 64'd1);

        // Flag vectors on all four geometries; edge n=1 is the acceptance edge.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            a = va[v]; b = vb[v]; a32 = va32[v]; b32 = vb32[v];
            sub = vs[v]; tag = 5'(v + 3);
            in_valid = 1'b1; sw_valid = 1'b1;
            for (int n = 1; n <= 8; n++) begin
                @(posedge clk);
                #1;
                if (n == 1) begin
                    in_valid = 1'b0; sw_valid = 1'b0;
                end
                chk("lat_s4", {63'd0, ov4}, {63'd0, n == 4});
                chk("lat_s1", {63'd0, ov1}, {63'd0, n == 1});
                chk("lat_s8", {63'd0, ov8}, {63'd0, n == 8});
                chk("lat_w32_s2", {63'd0, ov2}, {63'd0, n == 2});
                if (n == 4) begin
                    chk("s4_sum", sum4, ve[v]);
                    chk("s4_flags", {60'd0, fl4}, {60'd0, vf[v]});
                    chk("s4_tag", {59'd0, tg4}, 64'(v + 3));
                end
                if (n == 1) begin
                    chk("s1_sum", sum1, ve[v]);
                    chk("s1_flags", {60'd0, fl1}, {60'd0, vf[v]});
                end
                if (n == 8) begin
                    chk("s8_sum", sum8, ve[v]);
                    chk("s8_flags", {60'd0, fl8}, {60'd0, vf[v]});
                    chk("s8_tag", {59'd0, tg8}, 64'(v + 3));
                end
                if (n == 2) begin
                    chk("w32_sum", {32'd0, sum2}, {32'd0, ve32[v]});
                    chk("w32_flags", {60'd0, fl2}, {60'd0, vf32[v]});
                end
            end
        end

        // Ten back-to-back adds, consumer stalls for cycles 5..7.
        sent = 0;
        rcv = 0;
        for (int c = 0; c < 80 && rcv < 10; c++) begin
            @(negedge clk);
            in_valid = (sent < 10);
            a = 64'(sent); b = 64'(3 * sent); sub = 1'b0; tag = sent[4:0];
            out_ready = !(c >= 5 && c <= 7);
            #1;
            if (c >= 5 && c <= 7) begin
                chk("hold_in_ready", {63'd0, rdy4}, 64'd0);
                chk("hold_valid", {63'd0, ov4}, 64'd1);
                chk("hold_sum", sum4, 64'(4 * rcv));
                chk("hold_tag", {59'd0, tg4}, 64'(rcv));
            end
            acc = in_valid && rdy4;
            ret = ov4 && out_ready;
            if (ret) begin
                chk("stream_sum", sum4, 64'(4 * rcv));
                chk("stream_tag", {59'd0, tg4}, 64'(rcv));
                rcv++;
            end
            @(posedge clk);
            if (acc) sent++;
        end
        chk("stream_count", 64'(rcv), 64'd10);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("stream_no_dup", {63'd0, ov4}, 64'd0);
        end

        // Reset with one result presented and three more in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 64'(10 * (k + 1)); b = 64'd1; sub = 1'b0; tag = 5'(k + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_reset_valid", {63'd0, ov4}, 64'd1);
        chk("pre_reset_sum", sum4, 64'd11);
        reset_n = 1'b0;
        #1;
        chk("midreset_valid", {63'd0, ov4}, 64'd0);
        chk("midreset_sum", sum4, 64'd0);
        chk("midreset_flags", {60'd0, fl4}, 64'd0);
        chk("midreset_tag", {59'd0, tg4}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("post_reset_quiet", {63'd0, ov4}, 64'd0);
        end

        @(negedge clk);
        in_valid = 1'b1; a = 64'd2; b = 64'd2; sub = 1'b0; tag = 5'd9;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) in_valid = 1'b0;
            chk("post_reset_lat", {63'd0, ov4}, {63'd0, n == 4});
        end
        chk("post_reset_sum", sum4, 64'd4);
        chk("post_reset_tag", {59'd0, tg4}, 64'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
